// File: rtl/key_event_queue.sv
// PS/2 set-2 scan decoder feeding a first-word-fall-through ASCII key FIFO.
// Typematic repeats of the held key are suppressed; the held key is released on its break code.
module key_event_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_valid,
    input  logic [7:0]       scan_code,
    input  logic             clr,
    input  logic             key_pop,
    output logic             key_valid,
    output logic [7:0]       key_ascii,
    output logic [7:0]       key_held,
    output logic [CNT_W-1:0] key_count,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } dec_state_e;

    dec_state_e       state_q, state_d;
    logic [7:0]       held_code_q, held_code_d;
    logic [7:0]       held_ascii_q, held_ascii_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       mem [DEPTH];

    logic             mapped;
    logic [7:0]       ascii_code;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;

    // Returns {mapped, ascii}; unmapped codes return 0.
    function automatic logic [8:0] map_code(input logic [7:0] c);
        logic [8:0] r;
        r = '0;
        case (c)
            8'h1C: r = {1'b1, 8'h61}; 8'h32: r = {1'b1, 8'h62};
            8'h21: r = {1'b1, 8'h63}; 8'h23: r = {1'b1, 8'h64};
            8'h24: r = {1'b1, 8'h65}; 8'h2B: r = {1'b1, 8'h66};
            8'h34: r = {1'b1, 8'h67}; 8'h33: r = {1'b1, 8'h68};
            8'h43: r = {1'b1, 8'h69}; 8'h3B: r = {1'b1, 8'h6A};
            8'h42: r = {1'b1, 8'h6B}; 8'h4B: r = {1'b1, 8'h6C};
            8'h3A: r = {1'b1, 8'h6D}; 8'h31: r = {1'b1, 8'h6E};
            8'h44: r = {1'b1, 8'h6F}; 8'h4D: r = {1'b1, 8'h70};
            8'h15: r = {1'b1, 8'h71}; 8'h2D: r = {1'b1, 8'h72};
            8'h1B: r = {1'b1, 8'h73}; 8'h2C: r = {1'b1, 8'h74};
            8'h3C: r = {1'b1, 8'h75}; 8'h2A: r = {1'b1, 8'h76};
            8'h1D: r = {1'b1, 8'h77}; 8'h22: r = {1'b1, 8'h78};
            8'h35: r = {1'b1, 8'h79}; 8'h1A: r = {1'b1, 8'h7A};
            8'h45: r = {1'b1, 8'h30}; 8'h16: r = {1'b1, 8'h31};
            8'h1E: r = {1'b1, 8'h32}; 8'h26: r = {1'b1, 8'h33};
            8'h25: r = {1'b1, 8'h34}; 8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36}; 8'h3D: r = {1'b1, 8'h37};
            8'h3E: r = {1'b1, 8'h38}; 8'h46: r = {1'b1, 8'h39};
            8'h5A: r = {1'b1, 8'h0D};
            8'h29: r = {1'b1, 8'h20};
            8'h66: r = {1'b1, 8'h08};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign {mapped, ascii_code} = map_code(scan_code);

    always_comb begin
        state_d      = state_q;
        held_code_d  = held_code_q;
        held_ascii_d = held_ascii_q;
        push_req     = 1'b0;
        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    if (scan_code == 8'hF0) begin
                        state_d = BRK;
                    end else if (scan_code == 8'hE0) begin
                        state_d = EXT;
                    end else if (mapped && scan_code != held_code_q) begin
                        push_req     = 1'b1;
                        held_code_d  = scan_code;
                        held_ascii_d = ascii_code;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (scan_code == held_code_q) begin
                        held_code_d  = '0;
                        held_ascii_d = '0;
                    end
                end
                EXT:     state_d = (scan_code == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // A pop frees the slot, so a push into a full FIFO succeeds when paired with a pop.
        pop        = key_pop && key_valid;
        full       = (count_q == CNT_W'(DEPTH));
        push       = push_req && (!full || pop);
        overflow_d = overflow_q | (push_req && full && !pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        if (clr) begin
            state_d      = IDLE;
            held_code_d  = '0;
            held_ascii_d = '0;
            push         = 1'b0;
            overflow_d   = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            held_code_q  <= '0;
            held_ascii_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_code_q  <= held_code_d;
            held_ascii_q <= held_ascii_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= ascii_code;
        end
    end

    assign key_valid = (count_q != '0);
    assign key_ascii = key_valid ? mem[rd_ptr_q] : '0;
    assign key_held  = held_ascii_q;
    assign key_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: a reference decoder/FIFO model predicts
// queue contents, held key, count and overflow; outputs are checked every cycle.
module tb_key_event_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             scan_valid;
    logic [7:0]       scan_code;
    logic             clr;
    logic             key_pop;
    logic             key_valid;
    logic [7:0]       key_ascii;
    logic [7:0]       key_held;
    logic [CNT_W-1:0] key_count;
    logic             overflow;

    key_event_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .clr        (clr),
        .key_pop    (key_pop),
        .key_valid  (key_valid),
        .key_ascii  (key_ascii),
        .key_held   (key_held),
        .key_count  (key_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
    logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state: 0 idle, 1 break, 2 extended, 3 extended break.
    logic [7:0] m_q [$];
    int         m_state;
    logic [7:0] m_held;
    logic [7:0] m_held_a;
    logic       m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] tb_map(input logic [7:0] c);
        for (int i = 0; i < 26; i++)
            if (let_codes[i] == c) return {1'b1, 8'(8'h61 + i)};
        for (int i = 0; i < 10; i++)
            if (dig_codes[i] == c) return {1'b1, 8'(8'h30 + i)};
        if (c == 8'h5A) return {1'b1, 8'h0D};
        if (c == 8'h29) return {1'b1, 8'h20};
        if (c == 8'h66) return {1'b1, 8'h08};
        return 9'h000;
    endfunction

    function automatic logic [7:0] exp_head();
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_state  = 0;
        m_held   = 8'h00;
        m_held_a = 8'h00;
        m_ovf    = 1'b0;
    endtask

    task automatic model_update(input logic sv, input logic [7:0] code, input logic pop, input logic c);
        logic       push_req;
        logic [8:0] mp;
        if (c) begin
            model_reset();
            return;
        end
        push_req = 1'b0;
        mp       = tb_map(code);
        if (sv) begin
            case (m_state)
                0: begin
                    if (code == 8'hF0) m_state = 1;
                    else if (code == 8'hE0) m_state = 2;
                    else if (mp[8] && code != m_held) begin
                        push_req = 1'b1;
                        m_held   = code;
                        m_held_a = mp[7:0];
                    end
                end
                1: begin
                    m_state = 0;
                    if (code == m_held) begin
                        m_held   = 8'h00;
                        m_held_a = 8'h00;
                    end
                end
                2: m_state = (code == 8'hF0) ? 3 : 0;
                default: m_state = 0;
            endcase
        end
        if (pop && m_q.size() != 0) void'(m_q.pop_front());
        if (push_req) begin
            if (m_q.size() < DEPTH) m_q.push_back(mp[7:0]);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("key_count", 32'(key_count), 32'(m_q.size()));
        check("key_valid", 32'(key_valid), 32'(m_q.size() != 0));
        check("key_ascii", 32'(key_ascii), 32'(exp_head()));
        check("key_held",  32'(key_held),  32'(m_held_a));
        check("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    // Called just after a falling edge; applies inputs across one rising edge.
    task automatic step(input logic sv, input logic [7:0] code, input logic pop, input logic c);
        scan_valid = sv;
        scan_code  = code;
        key_pop    = pop;
        clr        = c;
        #1;
        check("no_bypass", 32'(key_ascii), 32'(exp_head()));
        model_update(sv, code, pop, c);
        @(negedge clk);
        scan_valid = 1'b0;
        key_pop    = 1'b0;
        clr        = 1'b0;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] code);
        step(1'b1, code, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int unsigned r;
        logic [7:0]  code;
        logic        pop;
        rst        = 1'b0;
        scan_valid = 1'b0;
        scan_code  = 8'h00;
        clr        = 1'b0;
        key_pop    = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Make, break: one entry, held set then released.
        send(8'h1C);
        check("held_a", 32'(key_held), 32'h61);
        send(8'hF0);
        send(8'h1C);
        check("held_release", 32'(key_held), 32'h00);
        check("one_entry", 32'(key_count), 32'd1);
        pop_one();

        // Typematic repeats are dropped.
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C);
        send(8'h1C); send(8'h1C);
        check("repeat_cnt", 32'(key_count), 32'd2);
        pop_one(); pop_one();

        // Extended sequences discarded, Enter queued.
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_empty", 32'(key_count), 32'd0);
        send(8'h5A);
        check("enter_head", 32'(key_ascii), 32'h0D);
        check("enter_held", 32'(key_held), 32'h0D);
        pop_one();
        send(8'hF0); send(8'h5A);

        // Pop while empty is ignored.
        pop_one();

        // Nine distinct keys into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            send(let_codes[i]);
            send(8'hF0);
            send(let_codes[i]);
        end
        check("full_cnt", 32'(key_count), 32'd8);
        check("full_ovf", 32'(overflow), 32'd1);
        check("full_head", 32'(key_ascii), 32'h61);
        step(1'b1, let_codes[9], 1'b1, 1'b0);
        check("pushpop_full", 32'(key_count), 32'd8);
        for (int i = 0; i < 8; i++) pop_one();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Flush overrides a same-cycle make and pop.
        send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h32); send(8'hF0); send(8'h32);
        send(8'h21);
        check("pre_clr_cnt", 32'(key_count), 32'd3);
        step(1'b1, 8'h22, 1'b1, 1'b1);
        check("clr_cnt", 32'(key_count), 32'd0);
        check("clr_held", 32'(key_held), 32'h00);
        check("clr_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset between F0 and its code byte.
        send(8'h1C);
        send(8'hF0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(8'h32);
        check("post_rst_head", 32'(key_ascii), 32'h62);
        check("post_rst_held", 32'(key_held), 32'h62);
        send(8'hF0); send(8'h32);

        // Randomised traffic over a small key pool.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:       code = 8'hF0;
                2:          code = 8'hE0;
                3, 4, 5, 6: code = let_codes[$urandom_range(0, 3)];
                7:          code = 8'($urandom_range(0, 255));
                default:    code = 8'h00;
            endcase
            pop = ($urandom_range(0, 99) < ((n < 200) ? 20 : 60));
            step((r < 8), code, pop, ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
